anim_sequencer: RTL and testbench
=================================

Name: anim_sequencer

Overview:
Parametrised frame sequencer for the 7-segment animation engine. It turns the clock into frame ticks with a programmable prescaler and steps a frame index through the selected animation. Four playback modes are supported: loop, ping-pong, one-shot and hold. The per-animation frame-count table is built in. Its frame output drives the segment pattern decoder directly.

Parameters:
ANIM_W, 3, width of the animation select; 2^ANIM_W table entries.
FRAME_W, 5, width of the frame index and of the limit values.
PRESCALE_W, 24, width of the prescaler counter and of the speed input.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  playback enable; low freezes the prescaler and the frame.
animation  input  ANIM_W  animation select.
mode  input  2  00 loop, 01 ping-pong, 10 one-shot, 11 hold.
speed  input  PRESCALE_W  tick period minus one, in clk cycles.
frame  output  FRAME_W  current frame index, registered.
tick  output  1  one-cycle pulse, high in the cycle a new frame first appears.
wrap  output  1  one-cycle pulse marking the end of a sequence pass.
done  output  1  sticky flag: one-shot sequence complete.

Behaviour:
- Limit table (frames per animation, indices 0..limit-1):
  - animation 0 -> 10
  - animation 1, 2, 3 -> 7
  - animation 4, 5 -> 6
  - all other values -> 2^FRAME_W-1
  - Values are truncated to FRAME_W bits.
- Reset (async, immediate): frame=0, tick=0, wrap=0, done=0, direction=up, prescaler=0, stored animation=0.
- Prescaler:
  - Counts only while enable=1.
  - When it equals speed: it returns to 0 and a tick event occurs on that edge.
  - speed=0 gives a tick on every enabled cycle.
  - Changing speed mid-count is allowed. If the count already exceeds the new speed, it keeps counting up, wraps modulo 2^PRESCALE_W, then matches.
- Tick event: tick<=1 and frame<=next on the same edge, so latency is 0 cycles between tick and the new frame.
- Next frame by mode (L = limit):
  - Loop:
    - frame = L-1 -> 0, with wrap=1.
    - Otherwise frame+1.
  - Ping-pong, direction up:
    - frame = L-1 -> frame-1, direction becomes down.
    - Otherwise frame+1.
  - Ping-pong, direction down:
    - frame = 0 -> 1, direction becomes up, wrap=1.
    - Otherwise frame-1.
  - One-shot:
    - frame < L-1 -> frame+1.
    - frame+1 = L-1 also sets done=1 on the same edge.
    - At L-1 the frame holds and tick still pulses.
  - Hold: frame unchanged; tick still pulses; wrap=0.
- L=1: frame stays 0 in every mode.
  - Loop and ping-pong pulse wrap on every tick.
  - One-shot sets done on the first tick.
- Animation change: animation is registered and compared every cycle. On a mismatch, the next edge forces frame=0, direction=up, done=0, prescaler=0, tick=0, wrap=0. This restart takes priority over a coincident tick. The restart also applies while enable=0.
- Mode change: direction=up and done=0 on the next edge; frame keeps its value.
- Ping-pong falling back to loop: if the mode changes while direction=down, the next step counts up from the current frame.
- enable=0: tick=0 and wrap=0; frame, direction and done hold.

Optional Feature:
ANIM_PINGPONG_EN
- Defined: mode 01 is ping-pong as specified above.
- Undefined: mode 01 behaves exactly as loop. The direction register and its logic are removed, and frame never decrements.

Test Plan:
- Reset mid-run: assert reset asynchronously between clock edges -> frame, tick, wrap and done read 0 immediately, before the next edge.
- Loop: animation=0, mode=00, speed=2 -> a tick every 3 cycles; frame runs 1..9, 0; wrap pulses together with the 9->0 tick.
- Ping-pong: animation=4, mode=01, speed=0 -> frame 1,2,3,4,5,4,3,2,1,0,1; wrap pulses only on the 0->1 step.
- One-shot: animation=1, mode=10, speed=0 -> frame reaches 6; done rises on the tick that lands on 6; further ticks keep frame=6; changing animation to 2 clears done and restarts at frame=0.
- Animation change while a tick is due: switch 0->3 on the cycle where the prescaler equals speed -> frame=0, tick=0, prescaler=0; the next tick arrives speed+1 cycles later.
- Default limit and enable gating: animation=7, FRAME_W=5, loop -> frame wraps 30->0; drop enable for 5 cycles -> no ticks and the frame holds.

Source files
------------

// File: rtl/anim_sequencer_if.sv
// ---------------------------------------------------------------------------
// anim_sequencer_if
// Control/status bundle of the 7-segment animation frame sequencer.
//
// Signals:
//   enable     playback enable (low freezes prescaler and frame)
//   animation  animation select
//   mode       00 loop, 01 ping-pong, 10 one-shot, 11 hold
//   speed      tick period minus one, in clk cycles
//   frame      current frame index (registered)
//   tick       one-cycle pulse in the cycle a new frame first appears
//   wrap       one-cycle pulse marking the end of a sequence pass
//   done       sticky one-shot completion flag
//
// Modports: master drives the controls and observes status, slave is the
// sequencer itself.
// ---------------------------------------------------------------------------
interface anim_sequencer_if #(
    parameter int ANIM_W     = 3,
    parameter int FRAME_W    = 5,
    parameter int PRESCALE_W = 24
);
    logic                  enable;
    logic [ANIM_W-1:0]     animation;
    logic [1:0]            mode;
    logic [PRESCALE_W-1:0] speed;
    logic [FRAME_W-1:0]    frame;
    logic                  tick;
    logic                  wrap;
    logic                  done;

    modport master (
        output enable, animation, mode, speed,
        input  frame, tick, wrap, done
    );

    modport slave (
        input  enable, animation, mode, speed,
        output frame, tick, wrap, done
    );
endinterface

// File: rtl/anim_sequencer.sv
// ---------------------------------------------------------------------------
// anim_sequencer
// Frame sequencer for the 7-segment animation engine. A programmable
// prescaler turns clk into frame ticks; each tick steps the frame index
// through the selected animation in loop, ping-pong, one-shot or hold mode.
// The frames-per-animation table is built in.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    anim_sequencer_if.slave: enable/animation/mode/speed in,
//          frame/tick/wrap/done out
//
// Build option:
//   ANIM_PINGPONG_EN  defined   -> mode 01 is ping-pong
//                     undefined -> mode 01 behaves as loop; the direction
//                                  register does not exist
// ---------------------------------------------------------------------------
module anim_sequencer #(
    parameter int ANIM_W     = 3,
    parameter int FRAME_W    = 5,
    parameter int PRESCALE_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    anim_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        MODE_LOOP     = 2'b00,
        MODE_PINGPONG = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

`ifdef ANIM_PINGPONG_EN
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;
`endif

    // Frames per animation; table values are truncated to the frame width.
    function automatic logic [FRAME_W-1:0] frame_limit(input logic [ANIM_W-1:0] anim);
        logic [FRAME_W-1:0] lim;
        case (int'(anim))
            0:       lim = FRAME_W'(10);
            1, 2, 3: lim = FRAME_W'(7);
            4, 5:    lim = FRAME_W'(6);
            default: lim = FRAME_W'((1 << FRAME_W) - 1);
        endcase
        return lim;
    endfunction

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [FRAME_W-1:0]    frame_q, frame_d;
    logic                  tick_q, tick_d;
    logic                  wrap_q, wrap_d;
    logic                  done_q, done_d;
    logic [ANIM_W-1:0]     anim_q;
    logic [1:0]            mode_q;
`ifdef ANIM_PINGPONG_EN
    dir_e                  dir_q, dir_d;
    dir_e                  dir_cur;
`endif

    logic [FRAME_W-1:0]    last_frame;
    logic [FRAME_W-1:0]    frame_inc;
    logic                  anim_change;
    logic                  mode_change;

    assign last_frame  = frame_limit(anim_q) - FRAME_W'(1);
    assign frame_inc   = frame_q + FRAME_W'(1);
    assign anim_change = (bus.animation != anim_q);
    assign mode_change = (bus.mode != mode_q);

`ifdef ANIM_PINGPONG_EN
    // A mode change restarts the direction; a tick on the same edge already
    // steps upward from the current frame.
    assign dir_cur = mode_change ? DIR_UP : dir_q;
`endif

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        presc_d = presc_q;
        frame_d = frame_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        done_d  = done_q;
`ifdef ANIM_PINGPONG_EN
        dir_d   = dir_q;
`endif

        if (anim_change) begin
            // Restart wins over a coincident tick and ignores enable.
            presc_d = '0;
            frame_d = '0;
            done_d  = 1'b0;
`ifdef ANIM_PINGPONG_EN
            dir_d   = DIR_UP;
`endif
        end else begin
            if (mode_change) begin
                done_d = 1'b0;
`ifdef ANIM_PINGPONG_EN
                dir_d  = DIR_UP;
`endif
            end

            if (bus.enable) begin
                if (presc_q == bus.speed) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    case (mode_e'(bus.mode))
                        MODE_HOLD: begin
                            frame_d = frame_q;
                        end
                        MODE_ONESHOT: begin
                            if (frame_q < last_frame) begin
                                frame_d = frame_inc;
                                if (frame_inc == last_frame) done_d = 1'b1;
                            end else begin
                                // Parked on the last frame (also covers a
                                // single-frame animation on its first tick).
                                done_d = 1'b1;
                            end
                        end
`ifdef ANIM_PINGPONG_EN
                        MODE_PINGPONG: begin
                            if (last_frame == '0) begin
                                frame_d = '0;
                                wrap_d  = 1'b1;
                            end else if (dir_cur == DIR_UP) begin
                                if (frame_q >= last_frame) begin
                                    frame_d = frame_q - FRAME_W'(1);
                                    dir_d   = DIR_DOWN;
                                end else begin
                                    frame_d = frame_inc;
                                end
                            end else if (frame_q == '0) begin
                                frame_d = FRAME_W'(1);
                                dir_d   = DIR_UP;
                                wrap_d  = 1'b1;
                            end else begin
                                frame_d = frame_q - FRAME_W'(1);
                            end
                        end
`endif
                        default: begin
                            // Loop (and mode 01 when ping-pong is not built).
                            if (frame_q >= last_frame) begin
                                frame_d = '0;
                                wrap_d  = 1'b1;
                            end else begin
                                frame_d = frame_inc;
                            end
                        end
                    endcase
                end else begin
                    // Free-running up-count: a count above a freshly lowered
                    // speed wraps through zero before it matches.
                    presc_d = presc_q + PRESCALE_W'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            frame_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            anim_q  <= '0;
            mode_q  <= MODE_LOOP;
`ifdef ANIM_PINGPONG_EN
            dir_q   <= DIR_UP;
`endif
        end else begin
            presc_q <= presc_d;
            frame_q <= frame_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            anim_q  <= bus.animation;
            mode_q  <= bus.mode;
`ifdef ANIM_PINGPONG_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign bus.frame = frame_q;
    assign bus.tick  = tick_q;
    assign bus.wrap  = wrap_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// ---------------------------------------------------------------------------
// tb_anim_sequencer
// Directed bench for anim_sequencer. Expected frame/wrap/done triples are
// queued when a stimulus step is set up and popped each time the DUT
// raises tick; tick spacing and idle wrap are checked while waiting.
// ---------------------------------------------------------------------------
module tb_anim_sequencer;

    localparam int ANIM_W     = 3;
    localparam int FRAME_W    = 5;
    localparam int PRESCALE_W = 24;
    localparam int TICK_BUDGET = 64;

    typedef struct {
        logic [FRAME_W-1:0] frame;
        logic               wrap;
        logic               done;
    } exp_t;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    anim_sequencer_if #(
        .ANIM_W(ANIM_W), .FRAME_W(FRAME_W), .PRESCALE_W(PRESCALE_W)
    ) bus ();

    anim_sequencer #(
        .ANIM_W(ANIM_W), .FRAME_W(FRAME_W), .PRESCALE_W(PRESCALE_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int f, input bit w, input bit d);
        exp_t e;
        e.frame = FRAME_W'(f);
        e.wrap  = w;
        e.done  = d;
        sb.push_back(e);
    endtask

    // Wait for n ticks; gap > 0 also checks the cycle distance to each tick.
    task automatic run_ticks(input int n, input int gap, input string tag);
        for (int k = 0; k < n; k++) begin
            int   waited = 0;
            bit   seen   = 1'b0;
            exp_t e;
            while (!seen && waited < TICK_BUDGET) begin
                @(negedge clk);
                waited++;
                if (bus.tick === 1'b1) seen = 1'b1;
                else check($sformatf("%s_idle_wrap_%0d", tag, k), 32'(bus.wrap), 32'd0);
            end
            check($sformatf("%s_tick_seen_%0d", tag, k), 32'(seen), 32'd1);
            if (sb.size() == 0) begin
                check($sformatf("%s_sb_underflow_%0d", tag, k), 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                if (seen) begin
                    if (gap > 0) check($sformatf("%s_gap_%0d", tag, k), 32'(waited), 32'(gap));
                    check($sformatf("%s_frame_%0d", tag, k), 32'(bus.frame), 32'(e.frame));
                    check($sformatf("%s_wrap_%0d", tag, k), 32'(bus.wrap), 32'(e.wrap));
                    check($sformatf("%s_done_%0d", tag, k), 32'(bus.done), 32'(e.done));
                end
            end
        end
    endtask

    task automatic check_restart(input string tag);
        @(negedge clk);
        check({tag, "_frame"}, 32'(bus.frame), 32'd0);
        check({tag, "_tick"},  32'(bus.tick),  32'd0);
        check({tag, "_wrap"},  32'(bus.wrap),  32'd0);
        check({tag, "_done"},  32'(bus.done),  32'd0);
    endtask

    initial begin
        // ---- reset state ----
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.animation = '0;
        bus.mode      = 2'b00;
        bus.speed     = PRESCALE_W'(2);
        repeat (3) @(negedge clk);
        bus.enable = 1'b1;
        reset      = 1'b0;
        check("rst_frame", 32'(bus.frame), 32'd0);
        check("rst_tick",  32'(bus.tick),  32'd0);
        check("rst_wrap",  32'(bus.wrap),  32'd0);
        check("rst_done",  32'(bus.done),  32'd0);

        // ---- loop, animation 0 (10 frames), tick every 3 cycles ----
        for (int i = 1; i <= 9; i++) push(i, 1'b0, 1'b0);
        push(0, 1'b1, 1'b0);
        run_ticks(10, 3, "loop");

        // ---- ping-pong, animation 4 (6 frames), tick every cycle ----
        bus.animation = ANIM_W'(4);
        bus.mode      = 2'b01;
        bus.speed     = '0;
        check_restart("pp_restart");
`ifdef ANIM_PINGPONG_EN
        begin
            int seq [11] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
            for (int i = 0; i < 11; i++) push(seq[i], (i == 10), 1'b0);
        end
`else
        for (int i = 1; i <= 11; i++) push(i % 6, ((i % 6) == 0), 1'b0);
`endif
        run_ticks(11, 1, "pp");

        // ---- one-shot, animation 1 (7 frames) ----
        bus.animation = ANIM_W'(1);
        bus.mode      = 2'b10;
        check_restart("os_restart");
        for (int i = 1; i <= 6; i++) push(i, 1'b0, (i == 6));
        push(6, 1'b0, 1'b1);
        push(6, 1'b0, 1'b1);
        run_ticks(8, 1, "os");

        // animation change clears done and restarts
        bus.animation = ANIM_W'(2);
        check_restart("os_anim2");
        for (int i = 1; i <= 6; i++) push(i, 1'b0, (i == 6));
        run_ticks(6, 1, "os2");

        // ---- asynchronous reset between edges ----
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_frame", 32'(bus.frame), 32'd0);
        check("arst_tick",  32'(bus.tick),  32'd0);
        check("arst_wrap",  32'(bus.wrap),  32'd0);
        check("arst_done",  32'(bus.done),  32'd0);
        @(negedge clk);
        bus.animation = '0;
        bus.mode      = 2'b00;
        bus.speed     = PRESCALE_W'(3);
        @(negedge clk);
        reset = 1'b0;

        // ---- animation change on the cycle a tick is due ----
        push(1, 1'b0, 1'b0);
        run_ticks(1, 4, "due_pre");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("due_quiet_%0d", i), 32'(bus.tick), 32'd0);
        end
        bus.animation = ANIM_W'(3);
        check_restart("due_restart");
        push(1, 1'b0, 1'b0);
        run_ticks(1, 4, "due_post");

        // ---- default limit (31 frames) and enable gating ----
        bus.animation = ANIM_W'(7);
        bus.speed     = '0;
        check_restart("dl_restart");
        for (int i = 1; i <= 30; i++) push(i, 1'b0, 1'b0);
        push(0, 1'b1, 1'b0);
        push(1, 1'b0, 1'b0);
        run_ticks(32, 1, "dl");
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("en_off_tick_%0d", i),  32'(bus.tick),  32'd0);
            check($sformatf("en_off_wrap_%0d", i),  32'(bus.wrap),  32'd0);
            check($sformatf("en_off_frame_%0d", i), 32'(bus.frame), 32'd1);
        end
        bus.enable = 1'b1;
        push(2, 1'b0, 1'b0);
        run_ticks(1, 1, "en_on");

        // ---- hold mode: ticks continue, frame stays ----
        bus.mode = 2'b11;
        for (int i = 0; i < 3; i++) push(2, 1'b0, 1'b0);
        run_ticks(3, 1, "hold");

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
